// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain pull-low enables.
// Optional watchdog on the device handshake is enabled with `define PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       ps2c_oe,
    output logic       ps2d_oe,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
`ifdef PS2_TX_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_INHIBIT   = 3'd1,
        S_START     = 3'd2,
        S_REQ       = 3'd3,
        S_WAIT_IDLE = 3'd4,
        S_DONE      = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       n_q, n_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic [1:0]       c_sync_q, d_sync_q;
    logic             c_prev_q;
    logic             ps2c_oe_q, ps2c_oe_d;
    logic             ps2d_oe_q, ps2d_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             shift_oe_s;
    logic             c_s, d_s, fall_s;

    assign c_s    = c_sync_q[1];
    assign d_s    = d_sync_q[1];
    assign fall_s = c_prev_q & ~c_s;

    // Pin synchronizers; reset to the idle-high level so no false fall appears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_sync_q <= 2'b11;
            d_sync_q <= 2'b11;
            c_prev_q <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[0], PS2C};
            d_sync_q <= {d_sync_q[0], PS2D};
            c_prev_q <= c_sync_q[1];
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            n_q       <= 4'd0;
            data_q    <= 8'h00;
            par_q     <= 1'b0;
            ps2c_oe_q <= 1'b0;
            ps2d_oe_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            n_q       <= n_d;
            data_q    <= data_d;
            par_q     <= par_d;
            ps2c_oe_q <= ps2c_oe_d;
            ps2d_oe_q <= ps2d_oe_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // Next-state logic; the data enable holds the start bit until the first fall.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        data_d     = data_q;
        par_d      = par_q;
        shift_oe_s = ps2d_oe_q;
        case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    state_d = S_INHIBIT;
                    data_d  = tx_data;
                    par_d   = odd_parity(tx_data);
                    cnt_d   = '0;
                    n_d     = 4'd0;
                end else begin
                    cnt_d = '0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_START: begin
                state_d = S_REQ;
                cnt_d   = '0;
            end
            S_REQ: begin
                if (fall_s) begin
                    if (n_q == 4'd10) begin
                        n_d     = 4'd11;
                        state_d = d_s ? S_ERR : S_WAIT_IDLE;
                    end else begin
                        n_d = n_q + 4'd1;
                        case (n_q)
                            4'd0, 4'd1, 4'd2, 4'd3,
                            4'd4, 4'd5, 4'd6, 4'd7: shift_oe_s = ~data_q[n_q[2:0]];
                            4'd8:                   shift_oe_s = ~par_q;
                            default:                shift_oe_s = 1'b0;
                        endcase
                    end
                end else begin
                    n_d = n_q;
                end
`ifdef PS2_TX_TIMEOUT_EN
                if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_WAIT_IDLE: begin
                if (c_s && d_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_IDLE;
                end
`ifdef PS2_TX_TIMEOUT_EN
                if (cnt_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE, S_ERR: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                n_d     = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                n_d     = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so every output is a flop.
    always_comb begin
        ps2c_oe_d = 1'b0;
        ps2d_oe_d = 1'b0;
        busy_d    = (state_d != S_IDLE);
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_d)
            S_INHIBIT: ps2c_oe_d = 1'b1;
            S_START: begin
                ps2c_oe_d = 1'b1;
                ps2d_oe_d = 1'b1;
            end
            S_REQ:   ps2d_oe_d = shift_oe_s;
            S_DONE:  done_d = 1'b1;
            S_ERR:   err_d = 1'b1;
            default: ps2d_oe_d = 1'b0;
        endcase
    end

    assign ps2c_oe = ps2c_oe_q;
    assign ps2d_oe = ps2d_oe_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Scoreboard bench for ps2_host_tx: a PS/2 device model clocks the byte out,
// expected data-line levels and end events are queued and checked by a monitor.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 200;
    localparam int H   = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       dev_c, dev_d;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       ps2c_oe, ps2d_oe, busy, done, err;
    logic       pin_c, pin_d;

    assign pin_c = dev_c & ~ps2c_oe;
    assign pin_d = dev_d & ~ps2d_oe;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .PS2C(pin_c), .PS2D(pin_d),
        .tx_data(tx_data), .tx_start(tx_start),
        .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // kind 0: data-line level at device sample; kind 1: end event (0 done, 1 err)
    typedef struct { int kind; int val; } exp_t;
    exp_t sb[$];

    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   busy_gap = 0;
    logic in_xfer = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (in_xfer && !busy) busy_gap++;
    endtask

    task automatic pop_check(input string name, input int kind, input logic [31:0] val);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got event with empty scoreboard", name);
        end else begin
            e = sb.pop_front();
            check({name, "_kind"}, kind, e.kind);
            check(name, val, e.val);
        end
    endtask

    task automatic monitor();
        logic dc_prev = 1'b1;
        int   rise_cnt = 0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                rise_cnt = 0;
            end else if (dev_c && !dc_prev) begin
                if (rise_cnt < 10) pop_check($sformatf("bit%0d", rise_cnt + 1), 0, ps2d_oe);
                rise_cnt++;
            end
            dc_prev = dev_c;
            if (done || err) begin
                check("done_err_excl", done & err, 1'b0);
                pop_check("end_event", 1, err);
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic issue(input logic [7:0] b, input logic hold);
        int hi, dhi;
        logic last_d;
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        check("busy_rise", busy, 1'b1);
        check("ps2c_oe_rise", ps2c_oe, 1'b1);
        if (!hold) tx_start = 1'b0;
        hi = 0;
        dhi = 0;
        last_d = 1'b0;
        while (ps2c_oe && hi < INH + 50) begin
            hi++;
            if (ps2d_oe) dhi++;
            last_d = ps2d_oe;
            tick();
        end
        check("inhibit_len", hi, INH + 1);
        check("start_bit_before_release", last_d, 1'b1);
        check("start_bit_len", dhi, 1);
        check("start_bit_held", ps2d_oe, 1'b1);
    endtask

    // mode 0: device ACKs, 1: no ACK, 2: reset after fall 5
    task automatic run_xfer(input logic [7:0] b, input logic [9:0] exp_bits,
                            input int n_push, input int mode, input logic hold);
        int d0, e0, w;
        for (int i = 0; i < n_push; i++) sb.push_back('{0, int'(exp_bits[i])});
        if (mode < 2) sb.push_back('{1, mode});
        d0 = done_cnt;
        e0 = err_cnt;
        issue(b, hold);
        busy_gap = 0;
        in_xfer = 1'b1;
        repeat (5) tick();
        for (int k = 1; k <= 11; k++) begin
            if (k == 11 && mode == 0) dev_d = 1'b0;
            dev_c = 1'b0;
            if (k == 5 && mode == 2) begin
                repeat (4) tick();
                #2 reset = 1'b1;
                #1;
                check("rst_ps2c_oe", ps2c_oe, 1'b0);
                check("rst_ps2d_oe", ps2d_oe, 1'b0);
                check("rst_busy", busy, 1'b0);
                dev_c = 1'b1;
                in_xfer = 1'b0;
                tick();
                tick();
                reset = 1'b0;
                repeat (20) tick();
                check("rst_no_done", done_cnt - d0, 0);
                check("rst_no_err", err_cnt - e0, 0);
                return;
            end
            repeat (H) tick();
            dev_c = 1'b1;
            repeat (H) tick();
            dev_d = 1'b1;
        end
        in_xfer = 1'b0;
        w = 0;
        while (busy && w < 100) begin
            tick();
            w++;
        end
        check("end_reached", busy, 1'b0);
        check("done_pulses", done_cnt - d0, (mode == 0) ? 1 : 0);
        check("err_pulses", err_cnt - e0, (mode == 1) ? 1 : 0);
        check("end_ps2c_oe", ps2c_oe, 1'b0);
        check("end_ps2d_oe", ps2d_oe, 1'b0);
        if (hold) begin
            check("busy_continuous", busy_gap, 0);
            tick();
            check("restart_after_idle", busy, 1'b1);
            tx_start = 1'b0;
        end
    endtask

    initial begin
        int e0;
        reset    = 1'b1;
        dev_c    = 1'b1;
        dev_d    = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        fork
            monitor();
        join_none
        repeat (3) tick();
        check("reset_ps2c_oe", ps2c_oe, 1'b0);
        check("reset_ps2d_oe", ps2d_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_err", err, 1'b0);
        reset = 1'b0;
        repeat (3) tick();

        // 0xED: bits 1,0,1,1,0,1,1,1 par 1 -> oe 0,1,0,0,1,0,0,0,0,0
        run_xfer(8'hED, 10'h012, 10, 0, 1'b0);
        repeat (5) tick();
        // 0x01: parity 0 -> oe 1 after fall 9
        run_xfer(8'h01, 10'h1FE, 10, 0, 1'b0);
        repeat (5) tick();
        // 0x3C with no ACK
        run_xfer(8'h3C, 10'h0C3, 10, 1, 1'b0);
        repeat (5) tick();
        // 0xFF with tx_start held through the transfer
        run_xfer(8'hFF, 10'h000, 10, 0, 1'b1);
        do_reset();
        // 0x55 aborted by reset after fall 5
        run_xfer(8'h55, 10'h00A, 4, 2, 1'b0);
        repeat (5) tick();

        e0 = err_cnt;
`ifdef PS2_TX_TIMEOUT_EN
        begin
            int cnt;
            sb.push_back('{1, 1});
            issue(8'hED, 1'b0);
            cnt = 0;
            while (!err && cnt < TMO + 100) begin
                tick();
                cnt++;
            end
            check("timeout_cycles", cnt, TMO);
            tick();
            check("timeout_busy_drop", busy, 1'b0);
            check("timeout_ps2c_oe", ps2c_oe, 1'b0);
            check("timeout_ps2d_oe", ps2d_oe, 1'b0);
            check("timeout_err_once", err_cnt - e0, 1);
        end
`else
        issue(8'hED, 1'b0);
        repeat (2 * TMO) tick();
        check("silent_no_err", err_cnt - e0, 0);
        check("silent_busy", busy, 1'b1);
        check("silent_ps2c_released", ps2c_oe, 1'b0);
`endif
        do_reset();
        repeat (5) tick();
        check("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
